// File: rtl/gpu_alu_pkg.sv
// gpu_alu_pkg: opcode encodings and flag bit positions shared by the ALU pipeline
package gpu_alu_pkg;
    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_SLL = 2;
    localparam int OP_SRL = 3;
    localparam int OP_SRA = 4;
    localparam int OP_AND = 5;
    localparam int OP_OR  = 6;
    localparam int OP_XOR = 7;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/gpu_alu_core.sv
// gpu_alu_core: combinational ALU datapath producing result and NZCV flags
module gpu_alu_core
    import gpu_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CTRL_WIDTH = 3,
    parameter int SAT_EN     = 1
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [CTRL_WIDTH-1:0] op,
    input  logic                  sat,
    output logic [DATA_WIDTH-1:0] result,
    output logic [3:0]            flags
);
    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] raw;
    logic [DATA_WIDTH-1:0] sat_val;
    logic                  is_add;
    logic                  is_sub;
    logic                  ovf;
    logic                  carry;

    // The extra top bit of the widened sum/difference is carry-out or borrow (a < b).
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign is_add  = op == CTRL_WIDTH'(OP_ADD);
    assign is_sub  = op == CTRL_WIDTH'(OP_SUB);
    assign ovf     = is_add ? (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]) :
                     is_sub ? (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]) : 1'b0;
    assign carry   = is_add ? sum[DATA_WIDTH] : is_sub ? diff[DATA_WIDTH] : 1'b0;
    // On overflow the true result has the sign of a, so clamp toward that side.
    assign sat_val = a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};

    // Select the raw operation result; unknown opcodes yield zero.
    always_comb begin
        raw = '0;
        case (op)
            CTRL_WIDTH'(OP_ADD): raw = sum[DATA_WIDTH-1:0];
            CTRL_WIDTH'(OP_SUB): raw = diff[DATA_WIDTH-1:0];
            CTRL_WIDTH'(OP_SLL): raw = a << b;
            CTRL_WIDTH'(OP_SRL): raw = a >> b;
            CTRL_WIDTH'(OP_SRA): raw = $unsigned($signed(a) >>> b);
            CTRL_WIDTH'(OP_AND): raw = a & b;
            CTRL_WIDTH'(OP_OR):  raw = a | b;
            CTRL_WIDTH'(OP_XOR): raw = a ^ b;
            default:             raw = '0;
        endcase
    end

    // Apply saturation, then derive N/Z from the final result.
    always_comb begin
        result         = (SAT_EN != 0 && sat && ovf) ? sat_val : raw;
        flags          = '0;
        flags[FLAG_N]  = result[MSB];
        flags[FLAG_Z]  = result == '0;
        flags[FLAG_C]  = carry;
        flags[FLAG_V]  = ovf;
    end
endmodule

// File: rtl/gpu_alu_pipe.sv
// gpu_alu_pipe: two-stage valid/ready pipeline wrapped around gpu_alu_core
module gpu_alu_pipe
    import gpu_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CTRL_WIDTH = 3,
    parameter int TAG_WIDTH  = 4,
    parameter int SAT_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [CTRL_WIDTH-1:0] in_op,
    input  logic                  in_sat,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [3:0]            out_flags,
    output logic [TAG_WIDTH-1:0]  out_tag
);
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_a;
    logic [DATA_WIDTH-1:0] s1_b;
    logic [CTRL_WIDTH-1:0] s1_op;
    logic                  s1_sat;
    logic [TAG_WIDTH-1:0]  s1_tag;
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_result;
    logic [3:0]            s2_flags;
    logic [TAG_WIDTH-1:0]  s2_tag;
    logic [DATA_WIDTH-1:0] core_result;
    logic [3:0]            core_flags;
    logic                  s1_adv;
    logic                  s2_adv;

    gpu_alu_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .CTRL_WIDTH(CTRL_WIDTH),
        .SAT_EN    (SAT_EN)
    ) u_core (
        .a     (s1_a),
        .b     (s1_b),
        .op    (s1_op),
        .sat   (s1_sat),
        .result(core_result),
        .flags (core_flags)
    );

    // A stage may advance when empty or when its successor advances.
    assign s2_adv     = !s2_valid || out_ready;
    assign s1_adv     = !s1_valid || s2_adv;
    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_flags  = s2_flags;
    assign out_tag    = s2_tag;

    // Pipeline registers; payload loads only with a valid op so a held output stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            s1_sat    <= 1'b0;
            s1_tag    <= '0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
            s2_tag    <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a   <= in_a;
                    s1_b   <= in_b;
                    s1_op  <= in_op;
                    s1_sat <= in_sat;
                    s1_tag <= in_tag;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result <= core_result;
                    s2_flags  <= core_flags;
                    s2_tag    <= s1_tag;
                end
            end
        end
    end
endmodule
